// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Request side is held stable until ready; read data returns later with rvalid.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, mask, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, mask, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus access per EX/MEM instruction, stalls the pipe
// while the access is in flight and returns extended load data with a one-cycle valid pulse.
module mem_lsu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_misaligned,
    output logic        o_load_valid,
    output logic [31:0] o_load_data,
    output logic [4:0]  o_load_rd,
    mem_lsu_if.master   dmem
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        load_valid_q, load_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  load_rd_q, load_rd_d;

    logic        access, size_b, size_h, start;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // funct3[1:0] 00 = byte, 01 = half, anything else is handled as a word
    assign access = i_valid & (i_mem_read | i_mem_write);
    assign size_b = (i_funct3[1:0] == 2'b00);
    assign size_h = (i_funct3[1:0] == 2'b01);

    assign o_misaligned = access & ((size_h & i_addr[0]) |
                                    (!size_b & !size_h & (i_addr[1:0] != 2'b00)));
    // done_q blocks reissue of the instruction still sitting in EX/MEM after completion
    assign start  = (state_q == StIdle) & access & !o_misaligned & !done_q;
    assign o_busy = (state_q != StIdle) | start;

    always_comb begin
        if (size_b) begin
            st_mask  = 4'b0001 << i_addr[1:0];
            st_wdata = {4{i_store_data[7:0]}};
        end else if (size_h) begin
            st_mask  = 4'b0011 << {i_addr[1], 1'b0};
            st_wdata = {2{i_store_data[15:0]}};
        end else begin
            st_mask  = 4'b1111;
            st_wdata = i_store_data;
        end
    end

    assign ld_byte = dmem.rdata[{off_q, 3'b000} +: 8];
    assign ld_half = dmem.rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = dmem.rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        load_rd_d    = load_rd_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StReq;
                    req_d    = 1'b1;
                    we_d     = i_mem_write;
                    addr_d   = {i_addr[31:2], 2'b00};
                    mask_d   = i_mem_write ? st_mask : 4'b1111;
                    wdata_d  = st_wdata;
                    funct3_d = i_funct3;
                    off_d    = i_addr[1:0];
                    rd_d     = i_rd;
                end
            end
            StReq: begin
                if (dmem.ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (dmem.rvalid) begin
                    state_d      = StIdle;
                    done_d       = 1'b1;
                    load_valid_d = 1'b1;
                    load_data_d  = ld_ext;
                    load_rd_d    = rd_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            done_q       <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            load_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            load_rd_q    <= load_rd_d;
        end
    end

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.mask    = mask_q;
    assign dmem.wdata   = wdata_q;
    assign o_load_valid = load_valid_q;
    assign o_load_data  = load_data_q;
    assign o_load_rd    = load_rd_q;

endmodule
